// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch redirect, one-cycle pipeline squash and misaligned-target lockout
module pc_redirect_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pc_src,
  input  logic [WIDTH-1:0] branch_target,
  input  logic stall,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic flush_if_id,
  output logic flush_id_ex,
  output logic flush_ex_mem,
  output logic squashing,
  output logic addr_err,
  output logic [CNT_W-1:0] taken_count
);
  typedef enum logic [1:0] {RUN, SQUASH, ERR} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic take, bad;
  assign bad = state_q == RUN && pc_src && |branch_target[1:0];
  assign take = state_q == RUN && pc_src && !bad;
  assign pc_out = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign squashing = state_q == SQUASH;
  assign addr_err = state_q == ERR;
  assign flush_if_id = state_q != RUN;
  assign flush_id_ex = state_q != RUN;
  assign flush_ex_mem = state_q != RUN;
  assign taken_count = cnt_q;
  // Redirect to an aligned target squashes for one cycle; a misaligned one locks the unit up until reset.
  always_comb begin
    state_d = take ? SQUASH : bad ? ERR : state_q == SQUASH ? RUN : state_q;
    pc_d = take ? branch_target : (state_q == ERR || bad || stall) ? pc_q : pc_plus4;
    cnt_d = (take && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // State, PC and saturating taken counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter WIDTH, 32, PC and branch-target width in bits.
REQ-002 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-003 Parameter CNT_W, 16, taken-branch counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_src  input  1  redirect request, from branch_unit.
REQ-007 branch_target  input  WIDTH  redirect address, from ex_mem.
REQ-008 stall  input  1  hold PC, from hazard unit.
REQ-009 pc_out  output  WIDTH  registered current fetch PC, to instruction memory and if_id.
REQ-010 pc_plus4  output  WIDTH  combinational pc_out + 4, modulo 2^WIDTH.
REQ-011 flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  registered squash controls.
REQ-012 squashing  output  1  high while state is SQUASH.
REQ-013 addr_err  output  1  sticky misaligned-target flag.
REQ-014 taken_count  output  CNT_W  count of accepted redirects.

Function
REQ-015 FSM SHALL have exactly three states: RUN, SQUASH, ERR.
REQ-016 RUN, pc_src=1, branch_target[1:0]=0: next pc_out=branch_target, regardless of stall; next state SQUASH; taken_count +1.
REQ-017 RUN, pc_src=1, branch_target[1:0]!=0: pc_out held; addr_err set; next state ERR; taken_count unchanged.
REQ-018 RUN, pc_src=0, stall=0: next pc_out=pc_out+4, wrapping 0xFFFFFFFC to 0x00000000.
REQ-019 RUN, pc_src=0, stall=1: pc_out held.
REQ-020 SQUASH SHALL last exactly one cycle, then RUN unconditionally.
REQ-021 In SQUASH: all three flush outputs and squashing =1; pc_src ignored (no redirect, no count); pc_out +4 if stall=0, else held.
REQ-022 Flush outputs SHALL be 0 in RUN; redirect-to-flush latency is one cycle (flush high in the cycle pc_out first shows the target).
REQ-023 ERR SHALL be absorbing until rst: pc_out held, all flushes =1, squashing=0, addr_err=1, pc_src and stall ignored.
REQ-024 taken_count SHALL saturate at all-ones and not wrap.
REQ-025 pc_plus4 SHALL track pc_out combinationally in every state with no added latency.

Reset
REQ-026 rst=1 at a clock edge: pc_out=RESET_PC, state=RUN, all flushes=0, squashing=0, addr_err=0, taken_count=0.
REQ-027 rst SHALL take priority over pc_src and stall in every state, including mid-SQUASH and in ERR.
REQ-028 Outputs SHALL be valid the first cycle after rst is deasserted; pc_src high in that cycle is honoured per REQ-016/017.

Verification
REQ-029 Sequential fetch: reset, stall=0, pc_src=0 for 4 cycles -> pc_out 0,4,8,12,16; flushes 0.
REQ-030 Taken branch under stall: pc_out=0x20, stall=1, pc_src=1, target=0x100 -> next cycle pc_out=0x100, three flushes=1, squashing=1, taken_count=1; following cycle flushes=0, pc_out=0x104.
REQ-031 Back-to-back pc_src: pc_src=1 two cycles, targets 0x40 then 0x80 -> pc_out=0x40 then 0x44; second request ignored; taken_count=1.
REQ-032 Misaligned target: pc_src=1, target=0x102 -> addr_err=1, flushes=1, pc_out held for 5+ cycles despite stall/pc_src toggling; rst clears to RESET_PC.
REQ-033 Wrap and saturation: pc_out=0xFFFFFFFC, stall=0 -> pc_out=0, pc_plus4=4; force 2^CNT_W+1 taken redirects -> taken_count=0xFFFF.
REQ-034 Reset mid-SQUASH: rst=1 in the SQUASH cycle -> next cycle state RUN, flushes=0, pc_out=RESET_PC, taken_count=0.
